mem_stage: RTL

Data-memory stage that consumes the EX/MEM pipeline register outputs: ALU result, store data, register-write enable, memory-write and memory-read strobes. It holds a word-addressed data RAM with a fixed multi-cycle access latency, stalls upstream while an access is in flight, and drives a registered MEM/WB bundle for the writeback stage. Non-memory operations pass through in one cycle.

---
 rtl/mem_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: word-addressed RAM with a fixed multi-cycle access
// latency, upstream stall while an access is in flight, and a registered MEM/WB bundle.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LAT        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_in,
  input  logic        we_in,
  input  logic        w_in,
  input  logic        r_in,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_data,
  output logic        wb_sel,
  output logic        wb_we,
  output logic        misalign_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic        w_q;
  logic        r_q;

  logic [31:0] mem [DEPTH];

  logic                  mem_op;
  logic                  aligned;
  logic                  done;
  logic                  is_load;
  logic [DEPTH_LOG2-1:0] idx;

  assign mem_op  = valid_in & (r_in | w_in);
  assign aligned = (alu_in[1:0] == 2'b00);
  assign done    = (state == ACCESS) && (cnt == 4'd0);
  // A combined read+write strobe is a store; only a pure read returns data.
  assign is_load = r_q & ~w_q;
  assign idx     = addr_q[DEPTH_LOG2+1:2];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    stall = 1'b0;
    if (state == IDLE && mem_op && aligned) stall = 1'b1;
    if (state == ACCESS && cnt != 4'd0)     stall = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      w_q          <= 1'b0;
      r_q          <= 1'b0;
      wb_valid     <= 1'b0;
      wb_alu       <= '0;
      wb_data      <= '0;
      wb_sel       <= 1'b0;
      wb_we        <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!valid_in) begin
            wb_valid <= 1'b0;
          end else if (!(r_in | w_in)) begin
            wb_valid     <= 1'b1;
            wb_alu       <= alu_in;
            wb_we        <= we_in;
            wb_sel       <= 1'b0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
          end else if (!aligned) begin
            wb_valid     <= 1'b1;
            wb_alu       <= alu_in;
            wb_we        <= 1'b0;
            wb_sel       <= 1'b0;
            wb_data      <= '0;
            misalign_err <= 1'b1;
          end else begin
            addr_q   <= alu_in;
            data_q   <= store_in;
            we_q     <= we_in;
            w_q      <= w_in;
            r_q      <= r_in;
            cnt      <= 4'(LAT - 1);
            state    <= ACCESS;
            wb_valid <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt      <= cnt - 4'd1;
            wb_valid <= 1'b0;
          end else begin
            wb_valid     <= 1'b1;
            wb_alu       <= addr_q;
            wb_we        <= we_q;
            wb_sel       <= is_load;
            wb_data      <= is_load ? mem[idx] : '0;
            misalign_err <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; gating the write with rst_n aborts a
  // pending store when reset lands on the completing edge.
  always_ff @(posedge clk) begin
    if (rst_n && done && w_q) mem[idx] <= data_q;
  end

endmodule
